// File: rtl/vslc_servo_cfg.sv
// vslc_servo_cfg: configuration front end for the servo pulse generator.
// Byte writes load shadow registers. A COMMIT copies the whole shadow set
// into the active outputs in one edge, at the next servo period boundary
// (rising edge of servo_fb), or on the next edge if the generator is off.
// Optional build macro: VSLC_SERVO_CFG_READBACK_EN adds a registered
// readback port (rd_addr/rd_data) for the shadow registers and status.
module vslc_servo_cfg #(
    parameter logic [7:0]  DEF_SET   = 8'd0,
    parameter logic [7:0]  DEF_RESET = 8'd0,
    parameter logic [15:0] DEF_FREQ  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        servo_fb,
    output logic [7:0]  servo_set_val,
    output logic [7:0]  servo_reset_val,
    output logic [15:0] servo_freq_val,
    output logic        servo_enabled,
    output logic        servo_value,
    output logic        commit_pending,
    output logic        cfg_err
`ifdef VSLC_SERVO_CFG_READBACK_EN
    ,
    input  logic [2:0]  rd_addr,
    output logic [7:0]  rd_data
`endif
);

    logic [7:0]  shadowSet_q,   shadowSet_d;
    logic [7:0]  shadowReset_q, shadowReset_d;
    logic [15:0] shadowFreq_q,  shadowFreq_d;
    logic        shadowEn_q,    shadowEn_d;
    logic        shadowVal_q,   shadowVal_d;

    logic [7:0]  activeSet_q,   activeSet_d;
    logic [7:0]  activeReset_q, activeReset_d;
    logic [15:0] activeFreq_q,  activeFreq_d;
    logic        activeEn_q,    activeEn_d;
    logic        activeVal_q,   activeVal_d;

    logic        pending_q, pending_d;
    logic        err_q,     err_d;
    logic        fb_q;

    logic        wrAccept;
    logic        fbRise;
    logic        commitOk;
    logic        errSet;
    logic        errClr;

    // Writes are held off while a commit waits, so the shadow set being
    // applied cannot change underneath it.
    assign wrAccept = wr_valid && !pending_q;
    assign fbRise   = servo_fb && !fb_q;
    assign commitOk = (shadowFreq_q >= {8'b0, shadowSet_q}) &&
                      (shadowFreq_q >= {8'b0, shadowReset_q});

    // Next-state: pending commit application, then shadow writes/commands.
    always_comb begin
        shadowSet_d   = shadowSet_q;
        shadowReset_d = shadowReset_q;
        shadowFreq_d  = shadowFreq_q;
        shadowEn_d    = shadowEn_q;
        shadowVal_d   = shadowVal_q;
        activeSet_d   = activeSet_q;
        activeReset_d = activeReset_q;
        activeFreq_d  = activeFreq_q;
        activeEn_d    = activeEn_q;
        activeVal_d   = activeVal_q;
        pending_d     = pending_q;
        err_d         = err_q;
        errSet        = 1'b0;
        errClr        = 1'b0;

        if (pending_q && (fbRise || !activeEn_q)) begin
            activeSet_d   = shadowSet_q;
            activeReset_d = shadowReset_q;
            activeFreq_d  = shadowFreq_q;
            activeEn_d    = shadowEn_q;
            activeVal_d   = shadowVal_q;
            pending_d     = 1'b0;
        end

        if (wrAccept) begin
            case (wr_addr)
                3'd0: shadowSet_d         = wr_data;
                3'd1: shadowReset_d       = wr_data;
                3'd2: shadowFreq_d[7:0]   = wr_data;
                3'd3: shadowFreq_d[15:8]  = wr_data;
                3'd4: begin
                    shadowEn_d  = wr_data[0];
                    shadowVal_d = wr_data[1];
                end
                3'd5: begin
                    if (commitOk) pending_d = 1'b1;
                    else          errSet    = 1'b1;
                end
                3'd6: errClr = 1'b1;
                3'd7: errSet = 1'b1;
                default: ;
            endcase
        end

        if (errClr) err_d = 1'b0;
        if (errSet) err_d = 1'b1;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadowSet_q   <= DEF_SET;
            shadowReset_q <= DEF_RESET;
            shadowFreq_q  <= DEF_FREQ;
            shadowEn_q    <= 1'b0;
            shadowVal_q   <= 1'b0;
            activeSet_q   <= DEF_SET;
            activeReset_q <= DEF_RESET;
            activeFreq_q  <= DEF_FREQ;
            activeEn_q    <= 1'b0;
            activeVal_q   <= 1'b0;
            pending_q     <= 1'b0;
            err_q         <= 1'b0;
            fb_q          <= 1'b1;
        end else begin
            shadowSet_q   <= shadowSet_d;
            shadowReset_q <= shadowReset_d;
            shadowFreq_q  <= shadowFreq_d;
            shadowEn_q    <= shadowEn_d;
            shadowVal_q   <= shadowVal_d;
            activeSet_q   <= activeSet_d;
            activeReset_q <= activeReset_d;
            activeFreq_q  <= activeFreq_d;
            activeEn_q    <= activeEn_d;
            activeVal_q   <= activeVal_d;
            pending_q     <= pending_d;
            err_q         <= err_d;
            fb_q          <= servo_fb;
        end
    end

    assign wr_ready        = !pending_q;
    assign servo_set_val   = activeSet_q;
    assign servo_reset_val = activeReset_q;
    assign servo_freq_val  = activeFreq_q;
    assign servo_enabled   = activeEn_q;
    assign servo_value     = activeVal_q;
    assign commit_pending  = pending_q;
    assign cfg_err         = err_q;

`ifdef VSLC_SERVO_CFG_READBACK_EN
    logic [7:0] rdData_q, rdData_d;

    // Readback mux over the shadow registers and status bits.
    always_comb begin
        rdData_d = 8'd0;
        case (rd_addr)
            3'd0: rdData_d = shadowSet_q;
            3'd1: rdData_d = shadowReset_q;
            3'd2: rdData_d = shadowFreq_q[7:0];
            3'd3: rdData_d = shadowFreq_q[15:8];
            3'd4: rdData_d = {6'b0, shadowVal_q, shadowEn_q};
            3'd5: rdData_d = {6'b0, err_q, pending_q};
            default: rdData_d = 8'd0;
        endcase
    end

    // Registered read data, one cycle behind rd_addr.
    always_ff @(posedge clk) begin
        if (!rst_n) rdData_q <= 8'd0;
        else        rdData_q <= rdData_d;
    end

    assign rd_data = rdData_q;
`endif

endmodule

// File: tb/tb_vslc_servo_cfg.sv
// tb_vslc_servo_cfg: self-checking bench for vslc_servo_cfg.
// A behavioural model tracks the expected outputs every cycle; directed
// scenarios add hand-computed literal expectations on top.
module tb_vslc_servo_cfg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [2:0]  wr_addr = 3'd0;
    logic [7:0]  wr_data = 8'd0;
    logic        servo_fb = 1'b0;
    logic [7:0]  servo_set_val;
    logic [7:0]  servo_reset_val;
    logic [15:0] servo_freq_val;
    logic        servo_enabled;
    logic        servo_value;
    logic        commit_pending;
    logic        cfg_err;
`ifdef VSLC_SERVO_CFG_READBACK_EN
    logic [2:0]  rd_addr = 3'd0;
    logic [7:0]  rd_data;
`endif

    int testsRun = 0;
    int testsFailed = 0;
    bit cmpEn = 1'b0;

    vslc_servo_cfg dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .servo_fb        (servo_fb),
        .servo_set_val   (servo_set_val),
        .servo_reset_val (servo_reset_val),
        .servo_freq_val  (servo_freq_val),
        .servo_enabled   (servo_enabled),
        .servo_value     (servo_value),
        .commit_pending  (commit_pending),
        .cfg_err         (cfg_err)
`ifdef VSLC_SERVO_CFG_READBACK_EN
        ,
        .rd_addr         (rd_addr),
        .rd_data         (rd_data)
`endif
    );

    always #5 clk = ~clk;

    // Model state: shadow and active configuration as plain integers.
    int  shSet, shReset, shFreq, shEn, shVal;
    int  acSet, acReset, acFreq, acEn, acVal;
    int  mPend, mErr, mPrevFb, mRd;

    task automatic checkOutput(input string name, input int act, input int exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: evaluated with the inputs present at each rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            shSet = 0; shReset = 0; shFreq = 16'hFFFF; shEn = 0; shVal = 0;
            acSet = 0; acReset = 0; acFreq = 16'hFFFF; acEn = 0; acVal = 0;
            mPend = 0; mErr = 0; mPrevFb = 1; mRd = 0;
        end else begin
            // readback reflects the state before this edge
            case (int'(rd_addr_m()))
                0: mRd = shSet;
                1: mRd = shReset;
                2: mRd = shFreq % 256;
                3: mRd = shFreq / 256;
                4: mRd = shVal * 2 + shEn;
                5: mRd = mErr * 2 + mPend;
                default: mRd = 0;
            endcase
            if (mPend == 1 && ((servo_fb && mPrevFb == 0) || acEn == 0)) begin
                acSet = shSet; acReset = shReset; acFreq = shFreq;
                acEn = shEn; acVal = shVal;
                mPend = 0;
            end else if (wr_valid && mPend == 0) begin
                case (int'(wr_addr))
                    0: shSet = wr_data;
                    1: shReset = wr_data;
                    2: shFreq = (shFreq / 256) * 256 + wr_data;
                    3: shFreq = wr_data * 256 + shFreq % 256;
                    4: begin shEn = wr_data % 2; shVal = (wr_data / 2) % 2; end
                    5: if (shFreq >= shSet && shFreq >= shReset) mPend = 1;
                       else mErr = 1;
                    6: mErr = 0;
                    default: mErr = 1;
                endcase
            end
            mPrevFb = servo_fb;
        end
    end

    function automatic int rd_addr_m();
`ifdef VSLC_SERVO_CFG_READBACK_EN
        return int'(rd_addr);
`else
        return 0;
`endif
    endfunction

    // Cycle-by-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("m_set",     servo_set_val,   acSet);
            checkOutput("m_reset",   servo_reset_val, acReset);
            checkOutput("m_freq",    servo_freq_val,  acFreq);
            checkOutput("m_en",      servo_enabled,   acEn);
            checkOutput("m_val",     servo_value,     acVal);
            checkOutput("m_pending", commit_pending,  mPend);
            checkOutput("m_ready",   wr_ready,        1 - mPend);
            checkOutput("m_err",     cfg_err,         mErr);
`ifdef VSLC_SERVO_CFG_READBACK_EN
            checkOutput("m_rd",      rd_data,         mRd);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [2:0] addr, input logic [7:0] data);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        // Reset then idle
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cmpEn = 1'b1;
        checkOutput("rst_set",   servo_set_val,   0);
        checkOutput("rst_reset", servo_reset_val, 0);
        checkOutput("rst_freq",  servo_freq_val,  16'hFFFF);
        checkOutput("rst_en",    servo_enabled,   0);
        checkOutput("rst_val",   servo_value,     0);
        checkOutput("rst_ready", wr_ready,        1);
        checkOutput("rst_err",   cfg_err,         0);
        tick();

        // Generator disabled: commit applies one cycle after accept
        applyStimulus(3'd0, 8'd20);
        applyStimulus(3'd1, 8'd40);
        applyStimulus(3'd2, 8'hE8);
        applyStimulus(3'd3, 8'h03);
        applyStimulus(3'd4, 8'h01);
        checkOutput("shadow_no_effect", servo_set_val, 0);
        applyStimulus(3'd5, 8'h00);
        checkOutput("dis_pending", commit_pending, 1);
        checkOutput("dis_set_old", servo_set_val,  0);
        tick();
        checkOutput("dis_set",     servo_set_val,   20);
        checkOutput("dis_reset",   servo_reset_val, 40);
        checkOutput("dis_freq",    servo_freq_val,  1000);
        checkOutput("dis_en",      servo_enabled,   1);
        checkOutput("dis_val",     servo_value,     0);
        checkOutput("dis_pend0",   commit_pending,  0);

        // Generator enabled: wait for fb rise
        servo_fb = 1'b0;
        applyStimulus(3'd0, 8'd30);
        applyStimulus(3'd5, 8'h00);
        for (int i = 0; i < 50; i++) begin
            checkOutput("en_wait_pend",  commit_pending, 1);
            checkOutput("en_wait_ready", wr_ready,       0);
            checkOutput("en_wait_set",   servo_set_val,  20);
            tick();
        end
        servo_fb = 1'b1;
        tick();
        checkOutput("en_rise_set",  servo_set_val,  30);
        checkOutput("en_rise_pend", commit_pending, 0);

        // fb rise on the accept edge must not apply
        applyStimulus(3'd0, 8'd25);
        servo_fb = 1'b0;
        tick();
        servo_fb = 1'b1;
        applyStimulus(3'd5, 8'h00);
        checkOutput("coin_pend", commit_pending, 1);
        checkOutput("coin_set",  servo_set_val,  30);
        servo_fb = 1'b0;
        tick();
        checkOutput("coin_still", servo_set_val, 30);
        servo_fb = 1'b1;
        tick();
        checkOutput("coin_applied", servo_set_val, 25);

        // Invalid commit, clear and bad address
        applyStimulus(3'd2, 8'd10);
        applyStimulus(3'd3, 8'd0);
        applyStimulus(3'd0, 8'd20);
        applyStimulus(3'd5, 8'h00);
        checkOutput("bad_err",  cfg_err,        1);
        checkOutput("bad_pend", commit_pending, 0);
        checkOutput("bad_set",  servo_set_val,  25);
        checkOutput("bad_freq", servo_freq_val, 1000);
        applyStimulus(3'd6, 8'h00);
        checkOutput("clr_err", cfg_err, 0);
        applyStimulus(3'd7, 8'h00);
        checkOutput("addr7_err", cfg_err, 1);

        // Reset while a commit is pending
        applyStimulus(3'd2, 8'hFF);
        servo_fb = 1'b0;
        tick();
        applyStimulus(3'd5, 8'h00);
        checkOutput("rp_pend", commit_pending, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("rp_pend0", commit_pending, 0);
        checkOutput("rp_set",   servo_set_val,  0);
        checkOutput("rp_freq",  servo_freq_val, 16'hFFFF);
        checkOutput("rp_err",   cfg_err,        0);
        servo_fb = 1'b1;
        tick();
        tick();
        checkOutput("rp_norise_set",  servo_set_val,  0);
        checkOutput("rp_norise_freq", servo_freq_val, 16'hFFFF);
        servo_fb = 1'b0;

        // Disabled with shadow enable 0: thresholds still load
        applyStimulus(3'd0, 8'd5);
        applyStimulus(3'd5, 8'h00);
        tick();
        checkOutput("off_set", servo_set_val, 5);
        checkOutput("off_en",  servo_enabled, 0);

`ifdef VSLC_SERVO_CFG_READBACK_EN
        // Readback of shadow FREQ high byte and status
        applyStimulus(3'd3, 8'h12);
        rd_addr = 3'd3;
        tick();
        checkOutput("rd_freq_hi", rd_data, 8'h12);
        rd_addr = 3'd5;
        applyStimulus(3'd5, 8'h00);
        tick();
        checkOutput("rd_status", rd_data, 8'h01);
`endif

        tick();
        tick();
        cmpEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
